fsm_input_sched: RTL



---
 rtl/fsm_sched_pkg.sv | 28 ++
 rtl/req_edge_latch.sv | 40 ++++
 rtl/fsm_input_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fsm_sched_pkg.sv
// Shared encodings and defaults for the pattern-detector input scheduler.
package fsm_sched_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_CLEAR = 3'd4;

  localparam logic SYM_ZERO = 1'b0;
  localparam logic SYM_ONE  = 1'b1;

  localparam int DEF_GAP     = 2;
  localparam int DEF_CLR_CYC = 2;
  localparam int DEF_TIMEOUT = 1000;
  localparam int DEF_CNT_W   = 8;

  typedef struct packed {
    logic pend0;
    logic pend1;
    logic last;
  } arb_req_t;

  // On a tie the symbol not granted last time wins.
  function automatic logic rr_pick(input arb_req_t r);
    if (r.pend0 && r.pend1) return ~r.last;
    return r.pend1 ? SYM_ONE : SYM_ZERO;
  endfunction
endpackage

// File: rtl/req_edge_latch.sv
// Rising-edge detector plus pending flag for one request line.
module req_edge_latch (
  input  logic clk_i,
  input  logic reset_i,
  input  logic req_i,
  input  logic clr_i,
  output logic pend_o,
  output logic ovr_o
);
  logic prev_q, pend_q, pend_d, ovr_q, ovr_d, rise;

  // prev_q resets low so a line already high after reset reads as an edge.
  assign rise = req_i & ~prev_q;

  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (rise) begin
      if (pend_q && !clr_i) ovr_d = 1'b1;
      pend_d = 1'b1;
    end else if (clr_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      prev_q <= req_i;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign pend_o = pend_q;
  assign ovr_o  = ovr_q;
endmodule

// File: rtl/fsm_input_sched.sv
// Sequences ONE/ZERO requests into single-cycle symbol strobes for the
// pattern detector, then counts matches and clears the detector.
module fsm_input_sched
  import fsm_sched_pkg::*;
#(
  parameter int GAP     = DEF_GAP,
  parameter int CLR_CYC = DEF_CLR_CYC,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             one_i,
  input  logic             zero_i,
  input  logic             det_out_i,
  output logic             sym_stb_o,
  output logic             sym_bit_o,
  output logic             det_rst_o,
  output logic             match_o,
  output logic             to_pulse_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             overrun_o,
  output logic             busy_o
);
  localparam int MAXP = (GAP > CLR_CYC) ? GAP : CLR_CYC;
  localparam int PW   = $clog2(MAXP + 1);
  localparam int IW   = $clog2(TIMEOUT);
  localparam logic [PW-1:0] GAP_LAST  = PW'(GAP - 1);
  localparam logic [PW-1:0] CLR_LAST  = PW'(CLR_CYC - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [PW-1:0]    cyc_q, cyc_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d, last_q, last_d, grant_q, grant_d;
  logic             pend0, pend1, ovr0, ovr1, clr0, clr1, to_fire, any_pend, pick;
  arb_req_t         req;

  req_edge_latch u_req0 (.clk_i(clk_i), .reset_i(reset_i), .req_i(zero_i),
                         .clr_i(clr0), .pend_o(pend0), .ovr_o(ovr0));
  req_edge_latch u_req1 (.clk_i(clk_i), .reset_i(reset_i), .req_i(one_i),
                         .clr_i(clr1), .pend_o(pend1), .ovr_o(ovr1));

  assign req      = '{pend0: pend0, pend1: pend1, last: last_q};
  assign any_pend = pend0 | pend1;
  assign pick     = rr_pick(req);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    idle_d  = idle_q;
    seen_d  = seen_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    to_fire = 1'b0;
    clr0    = 1'b0;
    clr1    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_pend) begin
          grant_d = pick;
          last_d  = pick;
          state_d = ST_ISSUE;
        end else if (seen_q) begin
          if (idle_q == IDLE_LAST) begin
            to_fire = 1'b1;
            cyc_d   = '0;
            state_d = ST_CLEAR;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        clr0    = (grant_q == SYM_ZERO);
        clr1    = (grant_q == SYM_ONE);
        seen_d  = 1'b1;
        idle_d  = '0;
        cyc_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cyc_q == GAP_LAST) state_d = ST_CHECK;
        else                   cyc_d   = cyc_q + 1'b1;
      end
      ST_CHECK: begin
        if (det_out_i) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          cyc_d   = '0;
          state_d = ST_CLEAR;
        end else if (any_pend) begin
          // Grant straight from CHECK so back-to-back strobes sit GAP+2 apart.
          grant_d = pick;
          last_d  = pick;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        seen_d = 1'b0;
        idle_d = '0;
        if (cyc_q == CLR_LAST) state_d = ST_IDLE;
        else                   cyc_d   = cyc_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      idle_q  <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      last_q  <= SYM_ONE;
      grant_q <= SYM_ZERO;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      idle_q  <= idle_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  assign sym_stb_o   = ~reset_i & (state_q == ST_ISSUE);
  assign sym_bit_o   = sym_stb_o & grant_q;
  assign det_rst_o   = reset_i | (state_q == ST_CLEAR);
  assign match_o     = ~reset_i & (state_q == ST_CHECK) & det_out_i;
  assign to_pulse_o  = ~reset_i & to_fire;
  assign match_cnt_o = cnt_q;
  assign overrun_o   = ovr0 | ovr1;
  assign busy_o      = ~reset_i & (state_q != ST_IDLE);
endmodule
